// File: rtl/cdm16_alu_core.sv
// cdm16_alu_core
//   16-bit datapath ALU of the CdM-16 core. It produces a combinational result
//   and CVZN flags for busD, the memory address output and the PS flag update.
//   It also keeps a registered copy of the flags, which is loaded on a latch strobe.
//
// Ports
//   input_clock    rising-edge clock for flags_q
//   reset          synchronous, active-high; clears flags_q
//   A, B           operands (bus0, bus1)
//   Cin            carry in (PS.C for ADC/SBC, or +1 for address increment)
//   op_type        operation class: 0 logic, 1 arith, 2 shift, 3 extend,
//                  4-7 add (address path)
//   func           function within the class
//   shif_count_ni  shift count minus one (0 -> 1 place, 7 -> 8 places)
//   flags_latch    load flags_q from CVZN on this edge
//   S              result (combinational)
//   CVZN           {C,V,Z,N} flags (combinational)
//   flags_q        registered CVZN
module cdm16_alu_core #(
    parameter int WIDTH = 16
) (
    input  logic             input_clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [2:0]       op_type,
    input  logic [2:0]       func,
    input  logic [2:0]       shif_count_ni,
    input  logic             flags_latch,
    output logic [WIDTH-1:0] S,
    output logic [3:0]       CVZN,
    output logic [3:0]       flags_q
);

    logic [3:0]  n;
    logic [4:0]  n16;
    logic [4:0]  n17;

    logic [15:0] x;
    logic [15:0] y;
    logic [16:0] sum;
    logic        arith_v;

    logic [16:0] shl_w;
    logic [16:0] shr_w;
    logic [16:0] sra_w;
    logic [15:0] rol_w;
    logic [15:0] ror_w;
    logic [16:0] rc;
    logic [16:0] rcl_w;
    logic [16:0] rcr_w;

    logic [15:0] res;
    logic        c_flag;
    logic        v_flag;

    assign n   = {1'b0, shif_count_ni} + 4'd1;
    assign n16 = 5'd16 - {1'b0, n};
    assign n17 = 5'd17 - {1'b0, n};

    // Adder operand selection. Classes other than ARITH fall through to
    // A+B+Cin, which is what the address path uses for op_type 4-7.
    always_comb begin
        x = A;
        y = B;
        if (op_type == 3'd1) begin
            case (func)
                3'd1:    y = ~B;
                3'd2:    x = ~A;
                3'd3:    y = 16'h0000;
                3'd4:    y = 16'hFFFF;
                default: ;
            endcase
        end
    end

    assign sum     = {1'b0, x} + {1'b0, y} + {16'd0, Cin};
    assign arith_v = (x[15] == y[15]) && (sum[15] != x[15]);

    // Each shift keeps one extra bit so that the last bit shifted out lands
    // in a known position and becomes C.
    assign shl_w = {1'b0, A} << n;
    assign shr_w = {A, 1'b0} >> n;
    assign sra_w = $signed({A, 1'b0}) >>> n;
    assign rol_w = (A << n) | (A >> n16);
    assign ror_w = (A >> n) | (A << n16);

    // RCL/RCR rotate the 17-bit value {Cin, A}.
    assign rc    = {Cin, A};
    assign rcl_w = (rc << n) | (rc >> n17);
    assign rcr_w = (rc >> n) | (rc << n17);

    always_comb begin
        res    = 16'h0000;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (op_type)
            3'd0: begin
                case (func)
                    3'd0: res = A & B;
                    3'd1: res = A | B;
                    3'd2: res = A ^ B;
                    3'd3: res = A & ~B;
                    3'd4: res = A;
                    3'd5: res = B;
                    3'd6: res = ~A;
                    3'd7: res = ~B;
                endcase
            end
            3'd2: begin
                case (func)
                    3'd1:    begin res = shr_w[16:1]; c_flag = shr_w[0];  end
                    3'd2:    begin res = sra_w[16:1]; c_flag = sra_w[0];  end
                    3'd3:    begin res = rol_w;       c_flag = rol_w[0];  end
                    3'd4:    begin res = ror_w;       c_flag = ror_w[15]; end
                    3'd5:    begin res = rcl_w[15:0]; c_flag = rcl_w[16]; end
                    3'd6:    begin res = rcr_w[15:0]; c_flag = rcr_w[16]; end
                    default: begin res = shl_w[15:0]; c_flag = shl_w[16]; end
                endcase
            end
            3'd3: begin
                case (func)
                    3'd0:    res = {{8{A[7]}}, A[7:0]};
                    3'd1:    res = {8'h00, A[7:0]};
                    3'd2:    res = {A[7:0], A[15:8]};
                    default: res = A;
                endcase
            end
            default: begin
                res    = sum[15:0];
                c_flag = sum[16];
                v_flag = arith_v;
            end
        endcase
    end

    assign S    = res;
    assign CVZN = {c_flag, v_flag, (res == 16'h0000), res[15]};

    always_ff @(posedge input_clock) begin
        if (reset)
            flags_q <= 4'b0000;
        else if (flags_latch)
            flags_q <= CVZN;
    end

endmodule

// File: tb/tb_cdm16_alu_core.sv
module tb_cdm16_alu_core;

    logic        input_clock = 1'b0;
    logic        reset;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic [2:0]  op_type;
    logic [2:0]  func;
    logic [2:0]  shif_count_ni;
    logic        flags_latch;
    logic [15:0] S;
    logic [3:0]  CVZN;
    logic [3:0]  flags_q;

    int checks = 0;
    int errors = 0;

    cdm16_alu_core #(.WIDTH(16)) dut (
        .input_clock   (input_clock),
        .reset         (reset),
        .A             (A),
        .B             (B),
        .Cin           (Cin),
        .op_type       (op_type),
        .func          (func),
        .shif_count_ni (shif_count_ni),
        .flags_latch   (flags_latch),
        .S             (S),
        .CVZN          (CVZN),
        .flags_q       (flags_q)
    );

    always #5 input_clock = ~input_clock;

    // Reference model: integer arithmetic for the adder, bit-at-a-time loops
    // for shifts and rotates.
    function automatic void ref_alu(input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, input logic [2:0] op,
                                    input logic [2:0] fn, input logic [2:0] cnt,
                                    output logic [15:0] s, output logic [3:0] f);
        logic        c;
        logic        v;
        logic        t;
        logic [15:0] r;
        logic [15:0] xa;
        logic [15:0] yb;
        logic [2:0]  fsel;
        int          steps;
        int          sum;
        int          sx;
        int          sy;
        int          ss;
        c = 1'b0;
        v = 1'b0;
        r = 16'h0000;
        steps = int'(cnt) + 1;
        if (op == 3'd0) begin
            case (fn)
                3'd0: r = a & b;
                3'd1: r = a | b;
                3'd2: r = a ^ b;
                3'd3: r = a & ~b;
                3'd4: r = a;
                3'd5: r = b;
                3'd6: r = ~a;
                default: r = ~b;
            endcase
        end else if (op == 3'd2) begin
            r = a;
            c = cin;
            for (int i = 0; i < steps; i++) begin
                case (fn)
                    3'd1: begin c = r[0];  r = {1'b0, r[15:1]};  end
                    3'd2: begin c = r[0];  r = {r[15], r[15:1]}; end
                    3'd3: begin c = r[15]; r = {r[14:0], r[15]}; end
                    3'd4: begin c = r[0];  r = {r[0], r[15:1]};  end
                    3'd5: begin t = r[15]; r = {r[14:0], c}; c = t; end
                    3'd6: begin t = r[0];  r = {c, r[15:1]}; c = t; end
                    default: begin c = r[15]; r = {r[14:0], 1'b0}; end
                endcase
            end
        end else if (op == 3'd3) begin
            case (fn)
                3'd0: r = {{8{a[7]}}, a[7:0]};
                3'd1: r = {8'h00, a[7:0]};
                3'd2: r = {a[7:0], a[15:8]};
                default: r = a;
            endcase
        end else begin
            fsel = (op == 3'd1) ? fn : 3'd0;
            xa = a;
            yb = b;
            case (fsel)
                3'd1: yb = ~b;
                3'd2: xa = ~a;
                3'd3: yb = 16'h0000;
                3'd4: yb = 16'hFFFF;
                default: ;
            endcase
            sum = int'(xa) + int'(yb) + int'(cin);
            r = sum[15:0];
            c = sum[16];
            sx = (int'(xa) >= 32768) ? int'(xa) - 65536 : int'(xa);
            sy = (int'(yb) >= 32768) ? int'(yb) - 65536 : int'(yb);
            ss = sx + sy + int'(cin);
            v = (ss > 32767) || (ss < -32768);
        end
        s = r;
        f = {c, v, (r == 16'h0000), r[15]};
    endfunction

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [2:0] op, input logic [2:0] fn, input logic [2:0] cnt);
        A = a;
        B = b;
        Cin = cin;
        op_type = op;
        func = fn;
        shif_count_ni = cnt;
        #1;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    logic [15:0] exp_s;
    logic [3:0]  exp_f;
    logic [3:0]  exp_fq;

    initial begin
        reset = 1'b1;
        flags_latch = 1'b0;
        apply(16'h0000, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);
        @(posedge input_clock);
        #1;
        chk4("reset_flags_q", flags_q, 4'b0000);
        reset = 1'b0;

        apply(16'h7FFF, 16'h0001, 1'b0, 3'd1, 3'd0, 3'd0);
        chk16("add_s", S, 16'h8000);
        chk4("add_f", CVZN, 4'b0101);

        apply(16'h0005, 16'h0005, 1'b1, 3'd1, 3'd1, 3'd0);
        chk16("sub_eq_s", S, 16'h0000);
        chk4("sub_eq_f", CVZN, 4'b1010);

        apply(16'h0003, 16'h0005, 1'b1, 3'd1, 3'd1, 3'd0);
        chk16("sub_borrow_s", S, 16'hFFFE);
        chk4("sub_borrow_f", CVZN, 4'b0001);

        apply(16'h8001, 16'h0000, 1'b0, 3'd2, 3'd0, 3'd0);
        chk16("shl1_s", S, 16'h0002);
        chk4("shl1_f", CVZN, 4'b1000);

        apply(16'h8001, 16'h0000, 1'b0, 3'd2, 3'd2, 3'd3);
        chk16("shra4_s", S, 16'hF800);
        chk4("shra4_f", CVZN, 4'b0001);

        apply(16'h8001, 16'h0000, 1'b0, 3'd2, 3'd4, 3'd0);
        chk16("ror1_s", S, 16'hC000);
        chk4("ror1_f", CVZN, 4'b1001);

        apply(16'h00F0, 16'h0F0F, 1'b0, 3'd0, 3'd0, 3'd0);
        chk16("and_s", S, 16'h0000);
        chk4("and_f", CVZN, 4'b0010);

        apply(16'h1280, 16'h0000, 1'b0, 3'd3, 3'd0, 3'd0);
        chk16("sext_s", S, 16'hFF80);
        chk4("sext_f", CVZN, 4'b0001);

        apply(16'h1000, 16'h0000, 1'b1, 3'd4, 3'd0, 3'd0);
        chk16("inc_s", S, 16'h1001);
        chk4("inc_f", CVZN, 4'b0000);

        apply(16'hFFFF, 16'h0000, 1'b1, 3'd4, 3'd0, 3'd0);
        chk16("inc_wrap_s", S, 16'h0000);
        chk4("inc_wrap_f", CVZN, 4'b1010);

        // flags_q load, hold, and reset overriding a latch
        @(negedge input_clock);
        flags_latch = 1'b1;
        apply(16'h0005, 16'h0005, 1'b1, 3'd1, 3'd1, 3'd0);
        @(posedge input_clock);
        #1;
        chk4("fq_load", flags_q, 4'b1010);

        @(negedge input_clock);
        flags_latch = 1'b0;
        apply(16'h7FFF, 16'h0001, 1'b0, 3'd1, 3'd0, 3'd0);
        @(posedge input_clock);
        #1;
        chk4("fq_hold", flags_q, 4'b1010);

        @(negedge input_clock);
        reset = 1'b1;
        flags_latch = 1'b1;
        @(posedge input_clock);
        #1;
        chk4("fq_reset_prio", flags_q, 4'b0000);
        exp_fq = 4'b0000;

        for (int k = 0; k < 600; k++) begin
            @(negedge input_clock);
            reset = ($urandom_range(0, 15) == 0);
            flags_latch = 1'($urandom);
            apply(pick_operand(), pick_operand(), 1'($urandom), 3'($urandom),
                  3'($urandom), 3'($urandom));
            ref_alu(A, B, Cin, op_type, func, shif_count_ni, exp_s, exp_f);
            chk16("rand_s", S, exp_s);
            chk4("rand_f", CVZN, exp_f);
            if (reset)
                exp_fq = 4'b0000;
            else if (flags_latch)
                exp_fq = exp_f;
            @(posedge input_clock);
            #1;
            chk4("rand_fq", flags_q, exp_fq);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
